// File: rtl/bcd_tick_counter.sv
// Cascaded BCD up/down counter advanced by an internal prescaler tick.
// Digit 0 sits in count[3:0]; the most significant digit wraps at TOP_LIMIT.
// Priority on every edge: clear, then load, then count step.
module bcd_tick_counter #(
  parameter int DIGITS    = 2,
  parameter int TOP_LIMIT = 10,
  parameter int TICK_DIV  = 50000000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry_out,
  output logic                  load_err
);

  localparam int PW = 30;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    TOP_MAX    = 4'(TOP_LIMIT - 1);

  logic [PW-1:0]       presc_reg;
  logic                tick_reg;
  logic                carry_reg;
  logic                load_err_reg;
  logic [4*DIGITS-1:0] count_reg;
  logic [4*DIGITS-1:0] count_next;
  logic                wrap_next;
  logic [DIGITS-1:0]   digit_ok;
  logic                load_ok;
  logic                step;
  logic                presc_wrap;

  // Scratch variables for the digit ripple below.
  logic [3:0]          digit_cur;
  logic [3:0]          digit_max;
  logic                ripple;

  assign presc_wrap = (presc_reg == PRESC_LAST);
  // A tick only advances the count if en is still high on the following edge.
  assign step       = tick_reg & en;

  // Per-digit range check of the load value; the top digit has its own limit.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_load_chk
      localparam logic [3:0] DMAX = (gi == DIGITS - 1) ? TOP_MAX : 4'd9;
      assign digit_ok[gi] = (load_val[4*gi +: 4] <= DMAX);
    end
  endgenerate

  assign load_ok = &digit_ok;

  // Next count for one step: carry/borrow ripples from digit 0 upward in one cycle.
  always_comb begin
    count_next = count_reg;
    ripple     = 1'b1;
    digit_cur  = 4'd0;
    digit_max  = 4'd9;
    for (int i = 0; i < DIGITS; i++) begin
      digit_cur = count_reg[4*i +: 4];
      digit_max = (i == DIGITS - 1) ? TOP_MAX : 4'd9;
      if (ripple) begin
        if (up_dn) begin
          if (digit_cur == digit_max) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = digit_cur + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (digit_cur == 4'd0) begin
            count_next[4*i +: 4] = digit_max;
          end else begin
            count_next[4*i +: 4] = digit_cur - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    // A ripple surviving past the top digit means the whole counter wrapped.
    wrap_next = ripple;
  end

  // Prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle tick.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (clear) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (en) begin
      if (presc_wrap) begin
        presc_reg <= '0;
        tick_reg  <= 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
        tick_reg  <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  // Count register with clear > load > step priority and one-cycle status pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_reg    <= '0;
      carry_reg    <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      carry_reg    <= 1'b0;
      load_err_reg <= 1'b0;
      if (clear) begin
        count_reg <= '0;
      end else if (load) begin
        if (load_ok) begin
          count_reg <= load_val;
        end else begin
          load_err_reg <= 1'b1;
        end
      end else if (step) begin
        count_reg <= count_next;
        carry_reg <= wrap_next;
      end
    end
  end

  assign count     = count_reg;
  assign tick      = tick_reg;
  assign carry_out = carry_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench: dut_a is 2 digits mod 100, dut_b is 2 digits mod 60,
// dut_c is a single digit with TICK_DIV=1. All share the same inputs.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] count_a, count_b;
  logic [3:0] count_c;
  logic       tick_a, tick_b, tick_c;
  logic       carry_a, carry_b, carry_c;
  logic       err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_tick_counter #(.DIGITS(2), .TOP_LIMIT(10), .TICK_DIV(4)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .count(count_a), .tick(tick_a),
    .carry_out(carry_a), .load_err(err_a));

  bcd_tick_counter #(.DIGITS(2), .TOP_LIMIT(6), .TICK_DIV(4)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .count(count_b), .tick(tick_b),
    .carry_out(carry_b), .load_err(err_b));

  bcd_tick_counter #(.DIGITS(1), .TOP_LIMIT(10), .TICK_DIV(1)) dut_c (
    .clk_in(clk), .rst_n_in(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .count(count_c), .tick(tick_c),
    .carry_out(carry_c), .load_err(err_c));

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One clock: pass the rising edge, return at the falling edge for sampling/driving.
  task automatic clk1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    clk1();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({count_a, tick_a, carry_a, err_a} !== 11'd0)
      begin errors++; $display("FAIL reset_in got %h/%b%b%b exp 00/000", count_a, tick_a, carry_a, err_a); end
    rst_n = 1'b1;
    clk1();
    checks++;
    if ({count_b, tick_b, carry_b, err_b} !== 11'd0)
      begin errors++; $display("FAIL reset_out got %h/%b%b%b exp 00/000", count_b, tick_b, carry_b, err_b); end
    $display("test_reset done");
  endtask

  task automatic test_count_up();
    logic [7:0] exp;
    en = 1'b1; up_dn = 1'b1;
    repeat (3) clk1();
    for (int k = 1; k <= 100; k++) begin
      clk1();
      checks++;
      if (tick_a !== 1'b1)
        begin errors++; $display("FAIL up_tick k=%0d got %b exp 1", k, tick_a); end
      clk1();
      exp = to_bcd(k % 100);
      checks++;
      if (count_a !== exp)
        begin errors++; $display("FAIL up_count k=%0d got %h exp %h", k, count_a, exp); end
      checks++;
      if (carry_a !== 1'(k == 100))
        begin errors++; $display("FAIL up_carry k=%0d got %b exp %b", k, carry_a, 1'(k == 100)); end
      clk1();
      clk1();
      checks++;
      if (tick_a !== 1'b0 || carry_a !== 1'b0)
        begin errors++; $display("FAIL up_idle k=%0d got tick %b carry %b exp 0 0", k, tick_a, carry_a); end
      $display("step %0d count %h carry %b", k, exp, 1'(k == 100));
    end
    en = 1'b0;
  endtask

  task automatic test_top_limit();
    do_clear();
    load = 1'b1; load_val = 8'h59;
    clk1();
    load = 1'b0;
    checks++;
    if (count_b !== 8'h59) begin errors++; $display("FAIL tl_load got %h exp 59", count_b); end
    en = 1'b1; up_dn = 1'b1;
    repeat (4) clk1();
    checks++;
    if (tick_b !== 1'b1) begin errors++; $display("FAIL tl_tick got %b exp 1", tick_b); end
    clk1();
    checks++;
    if (count_b !== 8'h00 || carry_b !== 1'b1)
      begin errors++; $display("FAIL tl_wrap_up got %h c%b exp 00 c1", count_b, carry_b); end
    checks++;
    if (count_a !== 8'h60 || carry_a !== 1'b0)
      begin errors++; $display("FAIL tl_a_up got %h c%b exp 60 c0", count_a, carry_a); end
    clk1();
    checks++;
    if (carry_b !== 1'b0) begin errors++; $display("FAIL tl_carry_drop got %b exp 0", carry_b); end
    up_dn = 1'b0;
    clk1();
    clk1();
    clk1();
    checks++;
    if (count_b !== 8'h59 || carry_b !== 1'b1)
      begin errors++; $display("FAIL tl_wrap_dn got %h c%b exp 59 c1", count_b, carry_b); end
    checks++;
    if (count_a !== 8'h59 || carry_a !== 1'b0)
      begin errors++; $display("FAIL tl_a_dn got %h c%b exp 59 c0", count_a, carry_a); end
    en = 1'b0;
    clk1();
    checks++;
    if (carry_b !== 1'b0) begin errors++; $display("FAIL tl_carry_drop2 got %b exp 0", carry_b); end
    $display("test_top_limit done");
  endtask

  task automatic test_load_err();
    load = 1'b1; load_val = 8'h3A;
    clk1();
    checks++;
    if (count_b !== 8'h59 || err_b !== 1'b1 || err_a !== 1'b1)
      begin errors++; $display("FAIL le_3a got %h e%b%b exp 59 e11", count_b, err_b, err_a); end
    load_val = 8'h72;
    clk1();
    checks++;
    if (count_b !== 8'h59 || err_b !== 1'b1)
      begin errors++; $display("FAIL le_72 got %h e%b exp 59 e1", count_b, err_b); end
    checks++;
    if (count_a !== 8'h72 || err_a !== 1'b0)
      begin errors++; $display("FAIL le_a72 got %h e%b exp 72 e0", count_a, err_a); end
    load_val = 8'h42;
    clk1();
    checks++;
    if (count_b !== 8'h42 || err_b !== 1'b0)
      begin errors++; $display("FAIL le_42 got %h e%b exp 42 e0", count_b, err_b); end
    load = 1'b0;
    clk1();
    checks++;
    if (count_b !== 8'h42 || err_b !== 1'b0)
      begin errors++; $display("FAIL le_hold got %h e%b exp 42 e0", count_b, err_b); end
    $display("test_load_err done");
  endtask

  task automatic test_clear_load_tick();
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    repeat (4) clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL clt_tick got %b exp 1", tick_a); end
    clear = 1'b1; load = 1'b1; load_val = 8'h42;
    clk1();
    clear = 1'b0; load = 1'b0;
    checks++;
    if (count_a !== 8'h00 || count_b !== 8'h00 || tick_a !== 1'b0 || carry_a !== 1'b0)
      begin errors++; $display("FAIL clt_clear got %h %h t%b c%b exp 00 00 t0 c0", count_a, count_b, tick_a, carry_a); end
    repeat (3) clk1();
    checks++;
    if (tick_a !== 1'b0 || count_a !== 8'h00)
      begin errors++; $display("FAIL clt_early got t%b %h exp t0 00", tick_a, count_a); end
    clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL clt_next_tick got %b exp 1", tick_a); end
    clk1();
    checks++;
    if (count_a !== 8'h01 || carry_a !== 1'b0)
      begin errors++; $display("FAIL clt_step got %h c%b exp 01 c0", count_a, carry_a); end
    // Load coincident with a tick wins over the step and leaves the prescaler running.
    repeat (3) clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL clt_tick2 got %b exp 1", tick_a); end
    load = 1'b1; load_val = 8'h25;
    clk1();
    load = 1'b0;
    checks++;
    if (count_a !== 8'h25 || carry_a !== 1'b0)
      begin errors++; $display("FAIL clt_load_step got %h c%b exp 25 c0", count_a, carry_a); end
    repeat (3) clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL clt_presc_kept got %b exp 1", tick_a); end
    clk1();
    checks++;
    if (count_a !== 8'h26) begin errors++; $display("FAIL clt_after_load got %h exp 26", count_a); end
    en = 1'b0;
    $display("test_clear_load_tick done");
  endtask

  task automatic test_en_hold();
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    clk1();
    clk1();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      checks++;
      if (tick_a !== 1'b0 || count_a !== 8'h00)
        begin errors++; $display("FAIL eh_hold i=%0d got t%b %h exp t0 00", i, tick_a, count_a); end
    end
    en = 1'b1;
    clk1();
    checks++;
    if (tick_a !== 1'b0) begin errors++; $display("FAIL eh_resume got %b exp 0", tick_a); end
    clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL eh_tick got %b exp 1", tick_a); end
    clk1();
    checks++;
    if (count_a !== 8'h01) begin errors++; $display("FAIL eh_step got %h exp 01", count_a); end
    repeat (3) clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL eh_tick2 got %b exp 1", tick_a); end
    en = 1'b0;
    clk1();
    checks++;
    if (count_a !== 8'h01 || tick_a !== 1'b0)
      begin errors++; $display("FAIL eh_discard got %h t%b exp 01 t0", count_a, tick_a); end
    $display("test_en_hold done");
  endtask

  task automatic test_tick_div1();
    do_clear();
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      clk1();
      checks++;
      if (tick_c !== 1'b1 || count_c !== 4'((k - 1) % 10) || carry_c !== 1'(k == 11))
        begin errors++; $display("FAIL div1 k=%0d got t%b %h c%b exp t1 %h c%b", k, tick_c, count_c, carry_c, 4'((k - 1) % 10), 1'(k == 11)); end
    end
    en = 1'b0;
    $display("test_tick_div1 done");
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 8'h37;
    clk1();
    load = 1'b0;
    checks++;
    if (count_a !== 8'h37) begin errors++; $display("FAIL ar_load got %h exp 37", count_a); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({count_a, tick_a, carry_a, err_a} !== 11'd0 || count_b !== 8'h00)
      begin errors++; $display("FAIL ar_async got %h %h t%b c%b e%b exp 00 00 t0 c0 e0", count_a, count_b, tick_a, carry_a, err_a); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    repeat (3) clk1();
    checks++;
    if (tick_a !== 1'b0) begin errors++; $display("FAIL ar_early got %b exp 0", tick_a); end
    clk1();
    checks++;
    if (tick_a !== 1'b1) begin errors++; $display("FAIL ar_first_tick got %b exp 1", tick_a); end
    en = 1'b0;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_top_limit();
    test_load_err();
    test_clear_load_tick();
    test_en_hold();
    test_tick_div1();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
